// File: rtl/mcu_local_bram_writer_fsm.sv
// mcu_local_bram_writer_fsm: writes framed AXI-Stream passes into a local BRAM
// through a registered write port, reporting done or framing/config errors.
module mcu_local_bram_writer_fsm #(
    parameter int DATA_WIDTH       = 16,
    parameter int DATA_STRB_WIDTH  = DATA_WIDTH / 8,
    parameter int ADDR_WIDTH       = 32,
    parameter int INTER_ITER_WIDTH = 32,
    parameter int GLO_FSM_WIDTH    = 2,
    parameter int GLO_FSM_STR      = 0,
    parameter int GLO_FSM_ERR      = 2,
    parameter int GLO_FSM_END      = 3
) (
    input  logic                        clk,
    input  logic                        rst,
    output logic                        bram_en,
    output logic [DATA_STRB_WIDTH-1:0]  bram_we,
    output logic [ADDR_WIDTH-1:0]       bram_addr,
    output logic [DATA_WIDTH-1:0]       bram_wrdata,
    input  logic [DATA_WIDTH-1:0]       s_axis_tdata,
    input  logic                        s_axis_tvalid,
    output logic                        s_axis_tready,
    input  logic                        s_axis_tlast,
    input  logic [GLO_FSM_WIDTH-1:0]    glo_fsm_state,
    input  logic [ADDR_WIDTH-1:0]       base_addr,
    input  logic [ADDR_WIDTH:0]         addr_counter_max,
    input  logic [INTER_ITER_WIDTH-1:0] inter_counter_max,
    output logic                        write_done,
    output logic                        error,
    output logic [1:0]                  error_code
);
    typedef enum logic [1:0] {IDLE, RUN, DONE, ERR} state_t;

    state_t                      state_q, state_d;
    logic [ADDR_WIDTH-1:0]       base_q, base_d, nm1_q, nm1_d, word_q, word_d, off_q, off_d;
    logic [INTER_ITER_WIDTH-1:0] mm1_q, mm1_d, pass_q, pass_d;
    logic                        en_q, en_d;
    logic [ADDR_WIDTH-1:0]       addr_q, addr_d;
    logic [DATA_WIDTH-1:0]       data_q, data_d;
    logic [1:0]                  code_q, code_d;

    logic start, abort, acc, last_word, frame_err, wr, zero_cfg;

    assign start         = glo_fsm_state == GLO_FSM_WIDTH'(GLO_FSM_STR);
    assign abort         = state_q == RUN && glo_fsm_state == GLO_FSM_WIDTH'(GLO_FSM_ERR);
    assign s_axis_tready = state_q == RUN && !abort;
    assign acc           = s_axis_tvalid && s_axis_tready;
    assign last_word     = word_q == nm1_q;
    assign frame_err     = acc && (last_word != s_axis_tlast);
    assign wr            = acc && !frame_err;
    assign zero_cfg      = addr_counter_max == '0 || inter_counter_max == '0;

    assign bram_en     = en_q;
    assign bram_we     = {DATA_STRB_WIDTH{en_q}};
    assign bram_addr   = addr_q;
    assign bram_wrdata = data_q;
    assign write_done  = state_q == DONE;
    assign error       = state_q == ERR;
    assign error_code  = code_q;

    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        nm1_d   = nm1_q;
        mm1_d   = mm1_q;
        word_d  = word_q;
        pass_d  = pass_q;
        off_d   = off_q;
        code_d  = code_q;
        case (state_q)
            IDLE: if (start) begin
                if (zero_cfg) begin
                    state_d = ERR;
                    code_d  = 2'd3;
                end else begin
                    state_d = RUN;
                    base_d  = base_addr;
                    nm1_d   = addr_counter_max[ADDR_WIDTH-1:0] - ADDR_WIDTH'(1);
                    mm1_d   = inter_counter_max - INTER_ITER_WIDTH'(1);
                    word_d  = '0;
                    pass_d  = '0;
                    off_d   = '0;
                end
            end
            RUN: if (abort) state_d = IDLE;
                 else if (frame_err) begin
                     state_d = ERR;
                     code_d  = last_word ? 2'd2 : 2'd1;
                 end else if (wr && last_word && pass_q == mm1_q) state_d = DONE;
            DONE: if (glo_fsm_state == GLO_FSM_WIDTH'(GLO_FSM_END)) state_d = IDLE;
            ERR: if (glo_fsm_state == GLO_FSM_WIDTH'(GLO_FSM_ERR)) begin
                state_d = IDLE;
                code_d  = 2'd0;
            end
            default: state_d = IDLE;
        endcase
        if (wr) begin
            off_d  = off_q + ADDR_WIDTH'(1);
            word_d = last_word ? '0 : word_q + ADDR_WIDTH'(1);
            pass_d = pass_q + INTER_ITER_WIDTH'(last_word);
        end
        en_d   = wr;
        addr_d = wr ? base_q + off_q : addr_q;
        data_d = wr ? s_axis_tdata : data_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            base_q  <= '0;
            nm1_q   <= '0;
            mm1_q   <= '0;
            word_q  <= '0;
            pass_q  <= '0;
            off_q   <= '0;
            en_q    <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            code_q  <= 2'd0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            nm1_q   <= nm1_d;
            mm1_q   <= mm1_d;
            word_q  <= word_d;
            pass_q  <= pass_d;
            off_q   <= off_d;
            en_q    <= en_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            code_q  <= code_d;
        end
    end
endmodule
